// File: rtl/cp0_exception_unit.sv
// Coprocessor-0 Status/Cause/EPC registers with prioritised exception
// acceptance, ERET handling and a post-redirect blanking window.
module cp0_exception_unit #(
    parameter logic [31:0] EXC_VECTOR   = 32'h8000_0180,
    parameter int unsigned BLANK_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid_M,
    input  logic [31:0] pc_M,
    input  logic        exc_undef_M,
    input  logic        exc_syscall_M,
    input  logic        exc_break_M,
    input  logic        exc_ovf_M,
    input  logic        eret_M,
    input  logic [5:0]  hw_int,
    input  logic        cp0_we,
    input  logic [4:0]  cp0_waddr,
    input  logic [31:0] cp0_wdata,
    input  logic [4:0]  cp0_raddr,
    output logic [31:0] cp0_rdata,
    output logic        exc_taken,
    output logic        redirect,
    output logic [31:0] redirect_pc,
    output logic        flush,
    output logic [31:0] status_o,
    output logic [31:0] cause_o,
    output logic [31:0] epc_o
);

    typedef enum logic {IDLE, BLANK} state_t;

    localparam logic [2:0] BLANK_LOAD = 3'(BLANK_CYCLES);

    state_t      state, state_next;
    logic [2:0]  cnt, cnt_next;

    logic        ie, exl;
    logic [7:0]  im;
    logic [5:0]  sync1, sync2, ip_hw;
    logic [1:0]  ip_sw;
    logic [4:0]  exc_code;
    logic [31:0] epc;

    logic        int_pend;
    logic        exc_any;
    logic [4:0]  exc_code_sel;
    logic        eret_go;

    assign status_o = {16'h0, im, 6'h0, exl, ie};
    assign cause_o  = {16'h0, ip_hw, ip_sw, 1'b0, exc_code, 2'b00};
    assign epc_o    = epc;

    assign int_pend = ie & ~exl & (|({ip_hw, ip_sw} & im));

    always_comb begin
        exc_any      = 1'b0;
        exc_code_sel = 5'd0;
        if (state == IDLE && valid_M) begin
            if (exc_undef_M) begin
                exc_any      = 1'b1;
                exc_code_sel = 5'd10;
            end else if (exc_syscall_M) begin
                exc_any      = 1'b1;
                exc_code_sel = 5'd8;
            end else if (exc_break_M) begin
                exc_any      = 1'b1;
                exc_code_sel = 5'd9;
            end else if (exc_ovf_M) begin
                exc_any      = 1'b1;
                exc_code_sel = 5'd12;
            end else if (int_pend) begin
                exc_any      = 1'b1;
                exc_code_sel = 5'd0;
            end
        end
    end

    assign eret_go = (state == IDLE) & valid_M & eret_M & ~exc_any;

    always_comb begin
        exc_taken   = exc_any;
        redirect    = exc_any | eret_go;
        redirect_pc = '0;
        if (exc_any)
            redirect_pc = EXC_VECTOR;
        else if (eret_go)
            redirect_pc = epc;
        flush = exc_any | eret_go | (state == BLANK);
    end

    // Counter holds the number of blanking cycles still to run, including the current one.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                if (exc_any || eret_go) begin
                    state_next = BLANK;
                    cnt_next   = BLANK_LOAD;
                end
            end
            BLANK: begin
                cnt_next = cnt - 3'd1;
                if (cnt == 3'd1)
                    state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1    <= '0;
            sync2    <= '0;
            ip_hw    <= '0;
            ip_sw    <= '0;
            ie       <= 1'b0;
            exl      <= 1'b0;
            im       <= '0;
            exc_code <= '0;
            epc      <= '0;
        end else begin
            sync1 <= hw_int;
            sync2 <= sync1;
            ip_hw <= sync2;
            // An accepted exception drops any mtc0 issued in the same cycle.
            if (exc_any) begin
                epc      <= pc_M;
                exl      <= 1'b1;
                exc_code <= exc_code_sel;
            end else begin
                if (cp0_we) begin
                    case (cp0_waddr)
                        5'd12: begin
                            ie  <= cp0_wdata[0];
                            exl <= cp0_wdata[1];
                            im  <= cp0_wdata[15:8];
                        end
                        5'd13:   ip_sw <= cp0_wdata[9:8];
                        5'd14:   epc   <= cp0_wdata;
                        default: ;
                    endcase
                end
                if (eret_go)
                    exl <= 1'b0;
            end
        end
    end

    always_comb begin
        case (cp0_raddr)
            5'd12:   cp0_rdata = status_o;
            5'd13:   cp0_rdata = cause_o;
            5'd14:   cp0_rdata = epc;
            default: cp0_rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_cp0_exception_unit.sv
// Self-checking bench: directed scenarios plus randomized traffic against a
// behavioural CP0 model (interrupt delay line as a queue, blanking as a count).
module tb_cp0_exception_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_M;
    logic [31:0] pc_M;
    logic        exc_undef_M, exc_syscall_M, exc_break_M, exc_ovf_M;
    logic        eret_M;
    logic [5:0]  hw_int;
    logic        cp0_we;
    logic [4:0]  cp0_waddr;
    logic [31:0] cp0_wdata;
    logic [4:0]  cp0_raddr;
    logic [31:0] cp0_rdata;
    logic        exc_taken, redirect, flush;
    logic [31:0] redirect_pc, status_o, cause_o, epc_o;

    localparam logic [31:0] VEC = 32'h8000_0180;
    localparam int          NBLANK = 2;

    cp0_exception_unit #(.EXC_VECTOR(VEC), .BLANK_CYCLES(NBLANK)) dut (
        .clk(clk), .rst_n(rst_n), .valid_M(valid_M), .pc_M(pc_M),
        .exc_undef_M(exc_undef_M), .exc_syscall_M(exc_syscall_M),
        .exc_break_M(exc_break_M), .exc_ovf_M(exc_ovf_M), .eret_M(eret_M),
        .hw_int(hw_int), .cp0_we(cp0_we), .cp0_waddr(cp0_waddr),
        .cp0_wdata(cp0_wdata), .cp0_raddr(cp0_raddr), .cp0_rdata(cp0_rdata),
        .exc_taken(exc_taken), .redirect(redirect), .redirect_pc(redirect_pc),
        .flush(flush), .status_o(status_o), .cause_o(cause_o), .epc_o(epc_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Behavioural model state
    logic        m_ie, m_exl;
    logic [7:0]  m_im;
    logic [1:0]  m_ipsw;
    logic [4:0]  m_code;
    logic [31:0] m_epc;
    int          m_blank;
    logic [5:0]  hwq[$];

    int          e_code;
    logic        e_taken, e_eret;

    task model_reset();
        m_ie = 1'b0; m_exl = 1'b0; m_im = '0; m_ipsw = '0;
        m_code = '0; m_epc = '0; m_blank = 0;
        hwq = '{6'd0, 6'd0, 6'd0};
    endtask

    function automatic logic [31:0] reg_val(input logic [4:0] a);
        case (a)
            5'd12:   return {16'h0, m_im, 6'h0, m_exl, m_ie};
            5'd13:   return {16'h0, hwq[0], m_ipsw, 1'b0, m_code, 2'b00};
            5'd14:   return m_epc;
            default: return 32'h0;
        endcase
    endfunction

    task check_cycle();
        logic        pend;
        logic [31:0] e_rpc;
        #1;
        pend   = m_ie && !m_exl && (({hwq[0], m_ipsw} & m_im) != 8'h0);
        e_code = -1;
        if (valid_M && m_blank == 0) begin
            if (exc_undef_M)        e_code = 10;
            else if (exc_syscall_M) e_code = 8;
            else if (exc_break_M)   e_code = 9;
            else if (exc_ovf_M)     e_code = 12;
            else if (pend)          e_code = 0;
        end
        e_taken = (e_code >= 0);
        e_eret  = valid_M && m_blank == 0 && eret_M && !e_taken;
        e_rpc   = e_taken ? VEC : (e_eret ? m_epc : 32'h0);
        check("exc_taken",   32'(exc_taken), 32'(e_taken));
        check("redirect",    32'(redirect), 32'(e_taken || e_eret));
        check("redirect_pc", redirect_pc, e_rpc);
        check("flush",       32'(flush), 32'(e_taken || e_eret || m_blank > 0));
        check("status",      status_o, reg_val(5'd12));
        check("cause",       cause_o, reg_val(5'd13));
        check("epc",         epc_o, reg_val(5'd14));
        check("rdata",       cp0_rdata, reg_val(cp0_raddr));
    endtask

    task advance();
        if (e_taken) begin
            m_epc   = pc_M;
            m_exl   = 1'b1;
            m_code  = 5'(e_code);
            m_blank = NBLANK;
        end else begin
            if (cp0_we) begin
                if (cp0_waddr == 5'd12) begin
                    m_ie  = cp0_wdata[0];
                    m_exl = cp0_wdata[1];
                    m_im  = cp0_wdata[15:8];
                end else if (cp0_waddr == 5'd13) begin
                    m_ipsw = cp0_wdata[9:8];
                end else if (cp0_waddr == 5'd14) begin
                    m_epc = cp0_wdata;
                end
            end
            if (e_eret) begin
                m_exl   = 1'b0;
                m_blank = NBLANK;
            end else if (m_blank > 0) begin
                m_blank--;
            end
        end
        hwq.push_back(hw_int);
        void'(hwq.pop_front());
        @(posedge clk);
        @(negedge clk);
    endtask

    task set_idle();
        valid_M = 1'b0; pc_M = '0;
        exc_undef_M = 1'b0; exc_syscall_M = 1'b0; exc_break_M = 1'b0; exc_ovf_M = 1'b0;
        eret_M = 1'b0; cp0_we = 1'b0; cp0_waddr = '0; cp0_wdata = '0; cp0_raddr = 5'd13;
    endtask

    task run_idle(input int n);
        set_idle();
        for (int i = 0; i < n; i++) begin
            check_cycle();
            advance();
        end
    endtask

    function automatic logic [4:0] pick_addr();
        case ($urandom % 4)
            0:       return 5'd12;
            1:       return 5'd13;
            2:       return 5'd14;
            default: return 5'($urandom);
        endcase
    endfunction

    initial begin
        rst_n  = 1'b0;
        hw_int = '0;
        set_idle();
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check_cycle();
        check("rst_status", status_o, 32'h0);
        check("rst_flush",  32'(flush), 32'h0);
        advance();

        // Syscall
        valid_M = 1'b1; exc_syscall_M = 1'b1; pc_M = 32'h0040_0010;
        check_cycle();
        check("sys_taken", 32'(exc_taken), 32'h1);
        check("sys_rpc",   redirect_pc, 32'h8000_0180);
        advance();
        set_idle();
        check_cycle();
        check("sys_epc",   epc_o, 32'h0040_0010);
        check("sys_code",  32'(cause_o[6:2]), 32'd8);
        check("sys_exl",   32'(status_o[1]), 32'h1);
        check("sys_flush1", 32'(flush), 32'h1);
        advance();
        check_cycle();
        check("sys_flush2", 32'(flush), 32'h1);
        advance();
        check_cycle();
        check("sys_flush_end", 32'(flush), 32'h0);
        advance();

        // Priority
        valid_M = 1'b1; exc_undef_M = 1'b1; exc_break_M = 1'b1; exc_ovf_M = 1'b1;
        pc_M = 32'h0040_0014;
        check_cycle(); advance();
        set_idle(); check_cycle();
        check("prio_undef", 32'(cause_o[6:2]), 32'd10);
        advance();
        run_idle(2);
        valid_M = 1'b1; exc_ovf_M = 1'b1; pc_M = 32'h0040_0018;
        check_cycle(); advance();
        set_idle(); check_cycle();
        check("prio_ovf", 32'(cause_o[6:2]), 32'd12);
        advance();
        run_idle(2);
        exc_undef_M = 1'b1; exc_syscall_M = 1'b1; exc_break_M = 1'b1; exc_ovf_M = 1'b1;
        check_cycle();
        check("invalid_ignored", 32'(exc_taken), 32'h0);
        advance();

        // Blanking
        set_idle();
        valid_M = 1'b1; exc_break_M = 1'b1; pc_M = 32'h0040_001c;
        check_cycle(); advance();
        exc_break_M = 1'b0; exc_syscall_M = 1'b1;
        check_cycle();
        check("blank_taken", 32'(exc_taken), 32'h0);
        advance();
        set_idle(); check_cycle();
        check("blank_code", 32'(cause_o[6:2]), 32'd9);
        advance();
        run_idle(1);

        // Interrupt
        cp0_we = 1'b1; cp0_waddr = 5'd12; cp0_wdata = 32'h0000_0401;
        check_cycle(); advance();
        set_idle();
        hw_int = 6'b000001; valid_M = 1'b1; pc_M = 32'h0040_0100;
        for (int i = 0; i < 4; i++) begin
            check_cycle();
            check("int_latency", 32'(exc_taken), 32'(i == 3));
            advance();
        end
        check_cycle();
        check("int_code", 32'(cause_o[6:2]), 32'd0);
        check("int_exl",  32'(status_o[1]), 32'h1);
        advance();
        for (int i = 0; i < 5; i++) begin
            check_cycle();
            check("int_no_reentry", 32'(exc_taken), 32'h0);
            advance();
        end

        // ERET
        set_idle();
        cp0_we = 1'b1; cp0_waddr = 5'd14; cp0_wdata = 32'h0040_0020;
        check_cycle(); advance();
        set_idle(); valid_M = 1'b1; eret_M = 1'b1;
        check_cycle();
        check("eret_rpc",   redirect_pc, 32'h0040_0020);
        check("eret_taken", 32'(exc_taken), 32'h0);
        advance();
        set_idle(); check_cycle();
        check("eret_exl", 32'(status_o[1]), 32'h0);
        advance();
        hw_int = '0;
        cp0_we = 1'b1; cp0_waddr = 5'd12; cp0_wdata = 32'h0;
        check_cycle(); advance();
        run_idle(4);

        // mtc0 vs exception, then reset during blanking
        valid_M = 1'b1; exc_ovf_M = 1'b1; pc_M = 32'h0040_0030;
        cp0_we = 1'b1; cp0_waddr = 5'd14; cp0_wdata = 32'h0000_1234;
        check_cycle(); advance();
        set_idle(); check_cycle();
        check("conflict_epc", epc_o, 32'h0040_0030);
        advance();
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_flush", 32'(flush), 32'h0);
        check("rst_mid_redirect", 32'(redirect), 32'h0);
        check("rst_mid_epc", epc_o, 32'h0);
        check("rst_mid_status", status_o, 32'h0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        check_cycle();
        check("rst_release_flush", 32'(flush), 32'h0);
        advance();

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            valid_M       = ($urandom % 4) != 0;
            pc_M          = $urandom & 32'hffff_fffc;
            exc_undef_M   = ($urandom % 12) == 0;
            exc_syscall_M = ($urandom % 12) == 0;
            exc_break_M   = ($urandom % 12) == 0;
            exc_ovf_M     = ($urandom % 12) == 0;
            eret_M        = ($urandom % 6) == 0;
            if (($urandom % 8) == 0) hw_int = 6'($urandom);
            cp0_we        = ($urandom % 4) == 0;
            cp0_waddr     = pick_addr();
            cp0_wdata     = $urandom;
            cp0_raddr     = pick_addr();
            check_cycle();
            advance();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
